csr_file: RTL and testbench
===========================

CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter XLEN, default 64, CSR and data width (32 or 64).
REQ-002 SHALL have parameter MTVEC_RESET, default 'h8000_0000, mtvec reset value.
REQ-003 SHALL have parameter HART_ID, default 0, value returned by mhartid.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous reset, active-low.
REQ-006 SHALL have ports raddr  input  12 read address; rdata  output  XLEN read data; rillegal  output  1 address unimplemented.
REQ-007 SHALL have ports we  input  1 write enable; waddr  input  12; wop  input  2 (00 write, 01 set, 10 clear, 11 no-op); wdata  input  XLEN.
REQ-008 SHALL have ports trap_valid  input  1; trap_cause, trap_pc, trap_tval  input  XLEN each.
REQ-009 SHALL have ports mret  input  1; instret_incr  input  1 retire pulse.
REQ-010 SHALL have ports mtvec, mepc  output  XLEN; mstatus_mie  output  1.

Function
REQ-011 SHALL implement mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mtval 0x343, mhartid 0xF14 (read-only).
REQ-012 SHALL drive rdata/rillegal combinationally from raddr and current state; unimplemented address -> rdata 0, rillegal 1.
REQ-013 SHALL read mstatus as MIE bit 3, MPIE bit 7, MPP bits 12:11 = 2'b11, all other bits 0.
REQ-014 SHALL compute the new value from the current value: write = wdata, set = old|wdata, clear = old&~wdata; visible on rdata the cycle after the edge.
REQ-015 SHALL apply WARL: mtvec bit 1 forced 0; mepc bits 1:0 forced 0; mstatus writes only MIE and MPIE.
REQ-016 SHALL ignore writes to mhartid, unimplemented addresses, and wop 11, with no state change.
REQ-017 SHALL on trap_valid in one cycle: mepc <= trap_pc with bits 1:0 cleared, mcause <= trap_cause, mtval <= trap_tval, MPIE <= MIE, MIE <= 0.
REQ-018 SHALL on mret: MIE <= MPIE, MPIE <= 1.
REQ-019 SHALL apply priority trap_valid > mret > CSR write: with trap_valid the CSR write and mret are dropped entirely; with mret, a same-cycle mstatus write is dropped, other writes proceed.
REQ-020 SHALL drive mtvec, mepc, mstatus_mie directly from registers (no combinational path from inputs).

Reset
REQ-021 SHALL while rst is low asynchronously set mtvec = MTVEC_RESET, MIE = 0, MPIE = 1, and mscratch, mepc, mcause, mtval, counters = 0.
REQ-022 SHALL on rst assertion mid-trap or mid-write abandon the update; only reset values remain.

Configuration
REQ-023 SHALL with CSR_COUNTERS_EN defined implement mcycle 0xB00 and minstret 0xB02, XLEN bits, read/write.
REQ-024 SHALL increment mcycle every cycle and minstret on each cycle instret_incr is 1, wrapping all-ones -> 0.
REQ-025 SHALL let a CSR write to a counter win over its increment that cycle: the written value appears next cycle with no +1.
REQ-026 SHALL without CSR_COUNTERS_EN treat 0xB00/0xB02 as unimplemented (rdata 0, rillegal 1, writes ignored) and have no counter flops.

Verification
REQ-027 SHALL cover reset: release rst -> mtvec = 'h8000_0000, rdata(0x300) = 'h1880, mstatus_mie 0.
REQ-028 SHALL cover set/clear: write 0x340 = 'hF0, set 'h0F, clear 'h30 -> rdata(0x340) = 'hCF.
REQ-029 SHALL cover a trap with a simultaneous write: MIE = 1, trap_valid with trap_pc 'h1003, cause 'h8000_0000_0000_0007, and a write 0x341 = 'h55 -> mepc = 'h1000, mcause as given, MIE 0, MPIE 1, the write dropped.
REQ-030 SHALL cover mret: after the trap, mret -> MIE 1, MPIE 1; mret with trap_valid in the same cycle -> trap behaviour only.
REQ-031 SHALL cover counters (CSR_COUNTERS_EN): write minstret = all-ones, then instret_incr for 2 cycles -> 1; write mcycle = 5 -> reads 5 next cycle, 6 the cycle after.
REQ-032 SHALL cover WARL: write mtvec 'h1003 -> reads 'h1001; read 0x7C0 -> rdata 0, rillegal 1.

Source files
------------

// File: rtl/csr_file.sv
// Machine-mode CSR file: mstatus/mtvec/mscratch/mepc/mcause/mtval/mhartid.
// Define CSR_COUNTERS_EN to add the mcycle (0xB00) and minstret (0xB02) counters.
module csr_file #(
  parameter int unsigned     XLEN        = 64,
  parameter logic [XLEN-1:0] MTVEC_RESET = 'h8000_0000,
  parameter int unsigned     HART_ID     = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [11:0]     raddr,
  output logic [XLEN-1:0] rdata,
  output logic            rillegal,
  input  logic            we,
  input  logic [11:0]     waddr,
  input  logic [1:0]      wop,
  input  logic [XLEN-1:0] wdata,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] trap_tval,
  input  logic            mret,
  input  logic            instret_incr,
  output logic [XLEN-1:0] mtvec,
  output logic [XLEN-1:0] mepc,
  output logic            mstatus_mie
);

  logic            mpie;
  logic [XLEN-1:0] mscratch;
  logic [XLEN-1:0] mcause;
  logic [XLEN-1:0] mtval;
  logic [XLEN-1:0] mstat;
  logic [XLEN:0]   wrd;
  logic [XLEN-1:0] old;
  logic [XLEN-1:0] nval;
  logic            wr_ok;

`ifdef CSR_COUNTERS_EN
  logic [XLEN-1:0] mcycle;
  logic [XLEN-1:0] minstret;
`endif

  always_comb begin
    mstat        = '0;
    mstat[3]     = mstatus_mie;
    mstat[7]     = mpie;
    mstat[12:11] = 2'b11;
  end

  // Returns {illegal, value} for a CSR address.
  function automatic logic [XLEN:0] csr_rd(input logic [11:0] a);
    logic [XLEN:0] r;
    r = {1'b0, {XLEN{1'b0}}};
    case (a)
      12'h300: r = {1'b0, mstat};
      12'h305: r = {1'b0, mtvec};
      12'h340: r = {1'b0, mscratch};
      12'h341: r = {1'b0, mepc};
      12'h342: r = {1'b0, mcause};
      12'h343: r = {1'b0, mtval};
      12'hF14: r = {1'b0, XLEN'(HART_ID)};
`ifdef CSR_COUNTERS_EN
      12'hB00: r = {1'b0, mcycle};
      12'hB02: r = {1'b0, minstret};
`endif
      default: r = {1'b1, {XLEN{1'b0}}};
    endcase
    return r;
  endfunction

  assign {rillegal, rdata} = csr_rd(raddr);

  always_comb begin
    wrd = csr_rd(waddr);
    old = wrd[XLEN-1:0];
    unique case (wop)
      2'b00:   nval = wdata;
      2'b01:   nval = old | wdata;
      2'b10:   nval = old & ~wdata;
      default: nval = old;
    endcase
    // A trap takes the whole cycle; read-only and unimplemented targets never write.
    wr_ok = we && (wop != 2'b11) && !wrd[XLEN]
         && (waddr != 12'hF14) && !trap_valid;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mtvec       <= MTVEC_RESET;
      mepc        <= '0;
      mscratch    <= '0;
      mcause      <= '0;
      mtval       <= '0;
      mstatus_mie <= 1'b0;
      mpie        <= 1'b1;
    end else if (trap_valid) begin
      mepc        <= trap_pc & ~XLEN'(3);
      mcause      <= trap_cause;
      mtval       <= trap_tval;
      mpie        <= mstatus_mie;
      mstatus_mie <= 1'b0;
    end else begin
      if (mret) begin
        mstatus_mie <= mpie;
        mpie        <= 1'b1;
      end else if (wr_ok && waddr == 12'h300) begin
        mstatus_mie <= nval[3];
        mpie        <= nval[7];
      end
      if (wr_ok) begin
        case (waddr)
          12'h305: mtvec    <= {nval[XLEN-1:2], 1'b0, nval[0]};
          12'h340: mscratch <= nval;
          12'h341: mepc     <= {nval[XLEN-1:2], 2'b00};
          12'h342: mcause   <= nval;
          12'h343: mtval    <= nval;
          default: ;
        endcase
      end
    end
  end

`ifdef CSR_COUNTERS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      if (wr_ok && waddr == 12'hB00) mcycle <= nval;
      else                           mcycle <= mcycle + 1'b1;
      if (wr_ok && waddr == 12'hB02) minstret <= nval;
      else if (instret_incr)         minstret <= minstret + 1'b1;
    end
  end
`else
  logic unused_incr;
  assign unused_incr = instret_incr;
`endif

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file (XLEN = 64).
// Counter vectors follow CSR_COUNTERS_EN as the DUT does.
module tb_csr_file;

  logic        clk;
  logic        rst;
  logic [11:0] raddr;
  logic [63:0] rdata;
  logic        rillegal;
  logic        we;
  logic [11:0] waddr;
  logic [1:0]  wop;
  logic [63:0] wdata;
  logic        trap_valid;
  logic [63:0] trap_cause;
  logic [63:0] trap_pc;
  logic [63:0] trap_tval;
  logic        mret;
  logic        instret_incr;
  logic [63:0] mtvec;
  logic [63:0] mepc;
  logic        mstatus_mie;

  int checks = 0;
  int errors = 0;

  csr_file dut (
    .clk(clk), .rst(rst),
    .raddr(raddr), .rdata(rdata), .rillegal(rillegal),
    .we(we), .waddr(waddr), .wop(wop), .wdata(wdata),
    .trap_valid(trap_valid), .trap_cause(trap_cause),
    .trap_pc(trap_pc), .trap_tval(trap_tval),
    .mret(mret), .instret_incr(instret_incr),
    .mtvec(mtvec), .mepc(mepc), .mstatus_mie(mstatus_mie)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic rd_chk(input string tag, input logic [11:0] a,
                        input logic [63:0] exp, input logic ill);
    raddr = a;
    #1;
    chk({tag, ".data"}, rdata, exp);
    chk({tag, ".ill"}, {63'd0, rillegal}, {63'd0, ill});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    we = 1'b0; wop = 2'b11; trap_valid = 1'b0;
    mret = 1'b0; instret_incr = 1'b0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [1:0] op,
                        input logic [63:0] d);
    we = 1'b1; waddr = a; wop = op; wdata = d;
    tick();
  endtask

  initial begin
    rst = 1'b0; raddr = '0; we = 1'b0; waddr = '0; wop = 2'b11;
    wdata = '0; trap_valid = 1'b0; trap_cause = '0; trap_pc = '0;
    trap_tval = '0; mret = 1'b0; instret_incr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;

    chk("rst.mtvec", mtvec, 64'h8000_0000);
    chk("rst.mie", {63'd0, mstatus_mie}, 64'd0);
    chk("rst.mepc", mepc, 64'd0);
    rd_chk("rst.mstatus", 12'h300, 64'h1880, 1'b0);
    rd_chk("rst.mscratch", 12'h340, 64'h0, 1'b0);

    csr_wr(12'h340, 2'b00, 64'hF0);
    csr_wr(12'h340, 2'b01, 64'h0F);
    rd_chk("set", 12'h340, 64'hFF, 1'b0);
    csr_wr(12'h340, 2'b10, 64'h30);
    rd_chk("clear", 12'h340, 64'hCF, 1'b0);
    csr_wr(12'h340, 2'b11, 64'h0);
    rd_chk("nop", 12'h340, 64'hCF, 1'b0);

    csr_wr(12'h305, 2'b00, 64'h1003);
    rd_chk("warl.mtvec", 12'h305, 64'h1001, 1'b0);
    chk("warl.mtvec_out", mtvec, 64'h1001);
    rd_chk("unimpl", 12'h7C0, 64'h0, 1'b1);
    csr_wr(12'hF14, 2'b00, 64'h5);
    rd_chk("mhartid", 12'hF14, 64'h0, 1'b0);
    csr_wr(12'h341, 2'b00, 64'h57);
    rd_chk("warl.mepc", 12'h341, 64'h54, 1'b0);
    chk("warl.mepc_out", mepc, 64'h54);

    csr_wr(12'h300, 2'b00, 64'h8);
    rd_chk("mstatus.wr", 12'h300, 64'h1808, 1'b0);
    chk("mstatus.mie", {63'd0, mstatus_mie}, 64'd1);

    trap_valid = 1'b1; trap_pc = 64'h1003;
    trap_cause = 64'h8000_0000_0000_0007; trap_tval = 64'hDEAD;
    we = 1'b1; waddr = 12'h341; wop = 2'b00; wdata = 64'h55;
    tick();
    chk("trap.mepc", mepc, 64'h1000);
    rd_chk("trap.mcause", 12'h342, 64'h8000_0000_0000_0007, 1'b0);
    rd_chk("trap.mtval", 12'h343, 64'hDEAD, 1'b0);
    rd_chk("trap.mstatus", 12'h300, 64'h1880, 1'b0);
    chk("trap.mie", {63'd0, mstatus_mie}, 64'd0);

    mret = 1'b1;
    tick();
    rd_chk("mret.mstatus", 12'h300, 64'h1888, 1'b0);
    chk("mret.mie", {63'd0, mstatus_mie}, 64'd1);

    mret = 1'b1; trap_valid = 1'b1; trap_pc = 64'h2002;
    trap_cause = 64'h3; trap_tval = 64'h0;
    tick();
    rd_chk("trapmret.mstatus", 12'h300, 64'h1880, 1'b0);
    chk("trapmret.mepc", mepc, 64'h2000);
    rd_chk("trapmret.mcause", 12'h342, 64'h3, 1'b0);

    mret = 1'b1; we = 1'b1; waddr = 12'h300; wop = 2'b00; wdata = 64'h0;
    tick();
    rd_chk("mretwr.mstatus", 12'h300, 64'h1888, 1'b0);
    mret = 1'b1; we = 1'b1; waddr = 12'h340; wop = 2'b00; wdata = 64'h77;
    tick();
    rd_chk("mretwr.mscratch", 12'h340, 64'h77, 1'b0);

`ifdef CSR_COUNTERS_EN
    csr_wr(12'hB02, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF);
    rd_chk("minstret.wr", 12'hB02, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    instret_incr = 1'b1;
    @(posedge clk);
    #1;
    tick_incr_keep: begin
      instret_incr = 1'b1;
    end
    tick();
    rd_chk("minstret.wrap", 12'hB02, 64'h1, 1'b0);
    csr_wr(12'hB00, 2'b00, 64'h5);
    rd_chk("mcycle.wr", 12'hB00, 64'h5, 1'b0);
    @(posedge clk);
    #1;
    rd_chk("mcycle.inc", 12'hB00, 64'h6, 1'b0);
`else
    rd_chk("nocnt.mcycle", 12'hB00, 64'h0, 1'b1);
    csr_wr(12'hB02, 2'b00, 64'h9);
    rd_chk("nocnt.minstret", 12'hB02, 64'h0, 1'b1);
`endif

    trap_valid = 1'b1; trap_pc = 64'h3000; trap_cause = 64'h2;
    we = 1'b0;
    rst = 1'b0;
    #1;
    chk("arst.mtvec", mtvec, 64'h8000_0000);
    chk("arst.mepc", mepc, 64'h0);
    @(posedge clk);
    #1;
    trap_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst.mepc_after", mepc, 64'h0);
    rd_chk("arst.mscratch", 12'h340, 64'h0, 1'b0);
    rd_chk("arst.mcause", 12'h342, 64'h0, 1'b0);
    rd_chk("arst.mstatus", 12'h300, 64'h1880, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
